// File: rtl/mem_wb_writeback_pkg.sv
// Shared definitions for the MEM/WB write-back slice: data width, WB control
// bit positions, load funct3 encodings and the MEM/WB register payload.
package mem_wb_writeback_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned WBCTL_W = 2;
  localparam int unsigned F3_W    = 3;

  // Bit positions inside ex_mem_wb_ctl
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;

  // Load size/sign encodings
  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  // Contents of the MEM/WB pipeline register
  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic [XLEN-1:0] data;
    logic            misaligned;
  } mem_wb_t;

endpackage

// File: rtl/mem_wb_writeback_if.sv
// MEM-stage to write-back bus.
//   master: drives the ex_mem_* slot, raw memory word and stall/flush,
//           observes the registered write-back outputs.
//   slave : the write-back stage itself.
interface mem_wb_writeback_if
  import mem_wb_writeback_pkg::*;
#(
  parameter int unsigned COUNT_W = 64
);

  logic               ex_mem_valid;
  logic [WBCTL_W-1:0] ex_mem_wb_ctl;
  logic               ex_mem_link;
  logic [F3_W-1:0]    ex_mem_funct3;
  logic [RD_W-1:0]    ex_mem_rd;
  logic [XLEN-1:0]    ex_mem_alu_result;
  logic [XLEN-1:0]    ex_mem_npc;
  logic [XLEN-1:0]    mem_read_data;
  logic               stall;
  logic               flush;

  logic               mem_wb_valid;
  logic [RD_W-1:0]    mem_wb_rd;
  logic               mem_wb_regwrite;
  logic [XLEN-1:0]    wb_writedata;
  logic               load_misaligned;
  logic [COUNT_W-1:0] retired_count;

  modport master (
    output ex_mem_valid, ex_mem_wb_ctl, ex_mem_link, ex_mem_funct3, ex_mem_rd,
           ex_mem_alu_result, ex_mem_npc, mem_read_data, stall, flush,
    input  mem_wb_valid, mem_wb_rd, mem_wb_regwrite, wb_writedata,
           load_misaligned, retired_count
  );

  modport slave (
    input  ex_mem_valid, ex_mem_wb_ctl, ex_mem_link, ex_mem_funct3, ex_mem_rd,
           ex_mem_alu_result, ex_mem_npc, mem_read_data, stall, flush,
    output mem_wb_valid, mem_wb_rd, mem_wb_regwrite, wb_writedata,
           load_misaligned, retired_count
  );

endinterface

// File: rtl/mem_wb_writeback_load_align.sv
// Combinational load aligner: picks the addressed byte/halfword out of a
// little-endian memory word, extends it per funct3, and flags misalignment.
//   word       : raw aligned memory word
//   offset     : byte offset within the word
//   funct3     : load size/sign encoding
//   value      : extended load value
//   misaligned : halfword on odd offset, or word on non-zero offset
module load_align
  import mem_wb_writeback_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [F3_W-1:0] funct3,
  output logic [XLEN-1:0] value,
  output logic            misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Byte k lives at word[8k+7:8k]
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    value      = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  value = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: value = {24'h0, byte_sel};
      F3_LH: begin
        value      = {{16{half_sel[15]}}, half_sel};
        misaligned = offset[0];
      end
      F3_LHU: begin
        value      = {16'h0, half_sel};
        misaligned = offset[0];
      end
      F3_LW:  misaligned = (offset != 2'b00);
      default: value = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back select feeding decode's register
// file write port; also counts retired instructions.
//   clock, reset : pipeline clock, asynchronous active-high reset
//   bus (slave)  : ex_mem_* slot, mem_read_data, stall, flush in;
//                  mem_wb_valid/rd/regwrite, wb_writedata, load_misaligned,
//                  retired_count out (all straight from flops)
module mem_wb_writeback
  import mem_wb_writeback_pkg::*;
#(
  parameter int unsigned COUNT_W    = 64,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  mem_wb_writeback_if.slave  bus
);

  logic [XLEN-1:0]    load_value;
  logic               align_mis;
  logic               memtoreg;
  logic               misaligned_c;
  logic               rd_is_zero_c;
  logic [XLEN-1:0]    data_c;
  logic               regwrite_c;
  mem_wb_t            wb_q;
  logic [COUNT_W-1:0] count_q;

  load_align u_load_align (
    .word       (bus.mem_read_data),
    .offset     (bus.ex_mem_alu_result[1:0]),
    .funct3     (bus.ex_mem_funct3),
    .value      (load_value),
    .misaligned (align_mis)
  );

  // Next-state values for the MEM/WB register
  always_comb begin
    memtoreg     = bus.ex_mem_wb_ctl[WB_MEMTOREG];
    misaligned_c = bus.ex_mem_valid & memtoreg & align_mis;
    rd_is_zero_c = ZERO_GUARD && (bus.ex_mem_rd == RD_W'(0));
    regwrite_c   = bus.ex_mem_valid & bus.ex_mem_wb_ctl[WB_REGWRITE]
                 & ~misaligned_c & ~rd_is_zero_c;
    // Link beats memtoreg; a misaligned load writes back zero
    if (bus.ex_mem_link)
      data_c = bus.ex_mem_npc;
    else if (memtoreg)
      data_c = align_mis ? XLEN'(0) : load_value;
    else
      data_c = bus.ex_mem_alu_result;
  end

  // Pipeline register: flush > stall > load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_q    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wb_q <= '0;
    end else if (bus.stall) begin
      wb_q.misaligned <= 1'b0;
    end else begin
      wb_q.valid      <= bus.ex_mem_valid;
      wb_q.rd         <= bus.ex_mem_rd;
      wb_q.regwrite   <= regwrite_c;
      wb_q.data       <= data_c;
      wb_q.misaligned <= misaligned_c;
      if (bus.ex_mem_valid)
        count_q <= count_q + COUNT_W'(1);
    end
  end

  assign bus.mem_wb_valid    = wb_q.valid;
  assign bus.mem_wb_rd       = wb_q.rd;
  assign bus.mem_wb_regwrite = wb_q.regwrite;
  assign bus.wb_writedata    = wb_q.data;
  assign bus.load_misaligned = wb_q.misaligned;
  assign bus.retired_count   = count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: vector table applied through a
// scoreboard queue, plus hand sequences for counter wrap and async reset.
module tb_mem_wb_writeback;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mem_wb_writeback_if #(.COUNT_W(64)) bus ();

  mem_wb_writeback #(.COUNT_W(64), .ZERO_GUARD(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  ctl;
    logic        link;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] npc;
    logic [31:0] rdata;
    logic        stall;
    logic        flush;
    logic        e_valid;
    logic [4:0]  e_rd;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_mis;
    logic [63:0] e_cnt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        mis;
    logic [63:0] cnt;
  } exp_t;

  localparam logic [31:0] RD = 32'h80FF_7F01;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(logic valid, logic [1:0] ctl, logic link, logic [2:0] f3,
                              logic [4:0] rd, logic [31:0] alu, logic [31:0] npc,
                              logic stall, logic flush, logic e_valid, logic [4:0] e_rd,
                              logic e_rw, logic [31:0] e_data, logic e_mis,
                              logic [63:0] e_cnt);
    vec_t v;
    v.valid = valid; v.ctl = ctl; v.link = link; v.f3 = f3; v.rd = rd;
    v.alu = alu; v.npc = npc; v.rdata = RD; v.stall = stall; v.flush = flush;
    v.e_valid = e_valid; v.e_rd = e_rd; v.e_rw = e_rw; v.e_data = e_data;
    v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ex_mem_valid      = v.valid;
    bus.ex_mem_wb_ctl     = v.ctl;
    bus.ex_mem_link       = v.link;
    bus.ex_mem_funct3     = v.f3;
    bus.ex_mem_rd         = v.rd;
    bus.ex_mem_alu_result = v.alu;
    bus.ex_mem_npc        = v.npc;
    bus.mem_read_data     = v.rdata;
    bus.stall             = v.stall;
    bus.flush             = v.flush;
  endtask

  task automatic check_all(input string tag, input exp_t e);
    chk({tag, ".valid"},    64'(bus.mem_wb_valid),    64'(e.valid));
    chk({tag, ".rd"},       64'(bus.mem_wb_rd),       64'(e.rd));
    chk({tag, ".regwrite"}, 64'(bus.mem_wb_regwrite), 64'(e.rw));
    chk({tag, ".data"},     64'(bus.wb_writedata),    64'(e.data));
    chk({tag, ".mis"},      64'(bus.load_misaligned), 64'(e.mis));
    chk({tag, ".count"},    bus.retired_count,        e.cnt);
  endtask

  exp_t zero_e;
  exp_t e;
  vec_t v;

  initial begin
    zero_e = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, data: 32'd0, mis: 1'b0, cnt: 64'd0};
    //          vld ctl    lnk f3      rd  alu            npc           stl flu  e_v e_rd e_rw e_data          mis cnt
    vecs.push_back(mk(1, 2'b10, 0, 3'b000, 5,  32'h0000_1234, 32'h4,        0, 0,  1, 5,  1, 32'h0000_1234, 0, 1));
    vecs.push_back(mk(1, 2'b11, 0, 3'b000, 7,  32'h3,         32'h8,        0, 0,  1, 7,  1, 32'hFFFF_FF80, 0, 2));
    vecs.push_back(mk(1, 2'b11, 0, 3'b100, 7,  32'h3,         32'h8,        0, 0,  1, 7,  1, 32'h0000_0080, 0, 3));
    vecs.push_back(mk(1, 2'b11, 0, 3'b000, 7,  32'h1,         32'h8,        0, 0,  1, 7,  1, 32'h0000_007F, 0, 4));
    vecs.push_back(mk(1, 2'b11, 0, 3'b001, 7,  32'h2,         32'h8,        0, 0,  1, 7,  1, 32'hFFFF_80FF, 0, 5));
    vecs.push_back(mk(1, 2'b11, 0, 3'b101, 7,  32'h0,         32'h8,        0, 0,  1, 7,  1, 32'h0000_7F01, 0, 6));
    vecs.push_back(mk(1, 2'b11, 0, 3'b010, 7,  32'h0,         32'h8,        0, 0,  1, 7,  1, 32'h80FF_7F01, 0, 7));
    vecs.push_back(mk(1, 2'b11, 0, 3'b001, 7,  32'h1,         32'h8,        0, 0,  1, 7,  0, 32'h0,         1, 8));
    vecs.push_back(mk(1, 2'b10, 0, 3'b001, 4,  32'h5,         32'h8,        0, 0,  1, 4,  1, 32'h5,         0, 9));
    vecs.push_back(mk(1, 2'b11, 0, 3'b010, 7,  32'h2,         32'h8,        0, 0,  1, 7,  0, 32'h0,         1, 10));
    vecs.push_back(mk(1, 2'b11, 0, 3'b010, 7,  32'h2,         32'h8,        1, 0,  1, 7,  0, 32'h0,         0, 10));
    vecs.push_back(mk(1, 2'b10, 0, 3'b000, 0,  32'h0000_DEAD, 32'h8,        0, 0,  1, 0,  0, 32'h0000_DEAD, 0, 11));
    vecs.push_back(mk(1, 2'b11, 1, 3'b010, 1,  32'h0,         32'h0000_0104,0, 0,  1, 1,  1, 32'h0000_0104, 0, 12));
    vecs.push_back(mk(0, 2'b10, 0, 3'b000, 9,  32'h55,        32'h8,        0, 0,  0, 9,  0, 32'h55,        0, 12));
    vecs.push_back(mk(1, 2'b10, 0, 3'b000, 3,  32'h33,        32'h8,        0, 0,  1, 3,  1, 32'h33,        0, 13));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 2'b10, 0, 3'b000, 12, 32'h99,      32'h8,        1, 0,  1, 3,  1, 32'h33,        0, 13));
    vecs.push_back(mk(1, 2'b10, 0, 3'b000, 12, 32'h99,        32'h8,        1, 1,  0, 0,  0, 32'h0,         0, 13));
    vecs.push_back(mk(1, 2'b10, 0, 3'b000, 6,  32'h77,        32'h8,        0, 1,  0, 0,  0, 32'h0,         0, 13));
    vecs.push_back(mk(1, 2'b11, 0, 3'b011, 2,  32'h0,         32'h8,        0, 0,  1, 2,  1, 32'h80FF_7F01, 0, 14));
    vecs.push_back(mk(1, 2'b11, 0, 3'b101, 8,  32'h2,         32'h8,        0, 0,  1, 8,  1, 32'h0000_80FF, 0, 15));
    vecs.push_back(mk(1, 2'b01, 0, 3'b000, 8,  32'h0,         32'h8,        0, 0,  1, 8,  0, 32'h0000_0001, 0, 16));

    // Reset state
    drive(mk(0, 2'b00, 0, 3'b000, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
    #12;
    check_all("reset", zero_e);
    @(negedge clock);
    reset = 1'b0;

    // Table vectors through the scoreboard
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i]);
      sb_q.push_back('{valid: vecs[i].e_valid, rd: vecs[i].e_rd, rw: vecs[i].e_rw,
                       data: vecs[i].e_data, mis: vecs[i].e_mis, cnt: vecs[i].e_cnt});
      @(posedge clock);
      #1;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: got 0 entries expected 1");
      end else begin
        e = sb_q.pop_front();
        check_all($sformatf("vec%0d", i), e);
      end
    end

    // Counter wrap at 2^64-1
    @(negedge clock);
    v = mk(1, 2'b10, 0, 3'b000, 10, 32'h0000_0AAA, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    force dut.count_q = {64{1'b1}};
    #1;
    chk("wrap.preload", bus.retired_count, {64{1'b1}});
    release dut.count_q;
    @(posedge clock);
    #1;
    chk("wrap.count", bus.retired_count, 64'd0);
    chk("wrap.rd", 64'(bus.mem_wb_rd), 64'd10);
    @(posedge clock);
    #1;
    chk("wrap.next", bus.retired_count, 64'd1);

    // Async reset between edges while stalled
    @(negedge clock);
    bus.stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", zero_e);
    @(posedge clock);
    #1;
    check_all("rst_held", zero_e);

    // First edge after deassertion loads normally
    @(negedge clock);
    reset = 1'b0;
    drive(mk(1, 2'b10, 0, 3'b000, 11, 32'h0000_ABCD, 32'h8, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clock);
    #1;
    check_all("post_rst", '{valid: 1'b1, rd: 5'd11, rw: 1'b1, data: 32'h0000_ABCD,
                            mis: 1'b0, cnt: 64'd1});

    // Async reset in the middle of a flush
    @(negedge clock);
    bus.flush = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    check_all("rst_flush", zero_e);
    @(negedge clock);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
